test_loopback: RTL

Far-end echo partner for the MAC test generator/checker pair: accepts frames on the MAC RX stream, stores each one in an internal circular buffer, and retransmits it unchanged on the MAC TX stream once its frame status is known. Frames are forwarded whole, back-to-back with a programmable gap. Frames that overflow the buffer, or that lack a status, are discarded. Used on the remote board or in simulation to close the loop for the PHY/link test.

---
 rtl/test_loopback.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/test_loopback.sv
// test_loopback: far-end echo partner that buffers each received MAC frame and retransmits it whole once its status is known.
// Build option: define TEST_LOOPBACK_DROP_ERR_EN to discard fr_err frames; undefined, fr_err frames are forwarded like fr_good.
// Ports: clk, rst (async, active-high);
//        mac_rx_data/valid/sof/eof plus fr_good/fr_err status pulse (in);
//        mac_tx_data/valid/sof/eof echoed stream (out);
//        frm_fwd_cnt/frm_drop_cnt saturating frame counters; ovf sticky out-of-space flag.
module test_loopback #(
  parameter int TEST_DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 11,
  parameter logic [15:0] PAUSE_SIZE = 16'd64
) (
  input  logic clk,
  input  logic rst,
  input  logic [TEST_DATA_WIDTH-1:0] mac_rx_data,
  input  logic mac_rx_valid,
  input  logic mac_rx_sof,
  input  logic mac_rx_eof,
  input  logic mac_rx_fr_good,
  input  logic mac_rx_fr_err,
  output logic [TEST_DATA_WIDTH-1:0] mac_tx_data,
  output logic mac_tx_valid,
  output logic mac_tx_sof,
  output logic mac_tx_eof,
  output logic [15:0] frm_fwd_cnt,
  output logic [15:0] frm_drop_cnt,
  output logic ovf
);
  localparam int W = TEST_DATA_WIDTH;
  // The launch cycle and the two-stage read pipeline supply the last idle cycle of the gap.
  localparam logic [15:0] PAUSE_LOAD = (PAUSE_SIZE == 16'd0) ? 16'd0 : PAUSE_SIZE - 16'd1;
  typedef logic [ADDR_WIDTH-1:0] ptr_t;
  typedef enum logic [1:0] {R_IDLE, R_FRAME, R_STAT, R_DISCARD} rx_state_t;
  typedef enum logic [1:0] {T_IDLE, T_READ, T_SEND, T_PAUSE} tx_state_t;
  logic [W:0] mem [2**ADDR_WIDTH];
  logic [W:0] ram_q;
  ptr_t wr_ptr, cmt_ptr, rd_ptr, wr_nxt, cmt_nxt, base, base_inc;
  rx_state_t rx_state, rx_next;
  tx_state_t tx_state, tx_next;
  logic [15:0] pause_cnt, pause_nxt;
  logic st_ok, st_bad, start, full, accept, pend, we, fwd_inc, ovf_set;
  logic [1:0] drop_inc;
  logic issue, avail, sending, q_eof;

  function automatic logic [15:0] sat(input logic [15:0] c, input logic [1:0] i);
    logic [16:0] s;
    s = {1'b0, c} + {15'd0, i};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

`ifdef TEST_LOOPBACK_DROP_ERR_EN
  assign st_ok  = mac_rx_fr_good;
  assign st_bad = mac_rx_fr_err & ~mac_rx_fr_good;
`else
  assign st_ok  = mac_rx_fr_good | mac_rx_fr_err;
  assign st_bad = 1'b0;
`endif

  // A sof always restarts writing at the end of the last committed frame.
  assign start    = mac_rx_valid & mac_rx_sof;
  assign base     = start ? cmt_ptr : wr_ptr;
  assign base_inc = base + 1'b1;
  assign full     = base_inc == rd_ptr;
  assign accept   = mac_rx_valid & (start | rx_state == R_FRAME);
  assign pend     = start & (rx_state == R_FRAME | rx_state == R_STAT);

  always_comb begin
    rx_next = rx_state;
    we = 1'b0;
    wr_nxt = wr_ptr;
    cmt_nxt = cmt_ptr;
    fwd_inc = 1'b0;
    drop_inc = {1'b0, pend};
    ovf_set = 1'b0;
    if (accept && full) begin
      ovf_set = 1'b1;
      drop_inc = {1'b0, pend} + 2'd1;
      wr_nxt = cmt_ptr;
      rx_next = mac_rx_eof ? R_IDLE : R_DISCARD;
    end else if (accept) begin
      we = 1'b1;
      wr_nxt = base_inc;
      if (!mac_rx_eof) rx_next = R_FRAME;
      else if (st_ok) begin
        cmt_nxt = base_inc;
        fwd_inc = 1'b1;
        rx_next = R_IDLE;
      end else if (st_bad) begin
        wr_nxt = cmt_ptr;
        drop_inc = {1'b0, pend} + 2'd1;
        rx_next = R_IDLE;
      end else rx_next = R_STAT;
    end else if (rx_state == R_STAT && (st_ok || st_bad)) begin
      cmt_nxt = st_ok ? wr_ptr : cmt_ptr;
      wr_nxt = st_ok ? wr_ptr : cmt_ptr;
      fwd_inc = st_ok;
      drop_inc = {1'b0, ~st_ok};
      rx_next = R_IDLE;
    end else if (rx_state == R_DISCARD && mac_rx_valid && mac_rx_eof) rx_next = R_IDLE;
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rx_state <= R_IDLE;
      wr_ptr <= '0;
      cmt_ptr <= '0;
      ovf <= 1'b0;
      frm_fwd_cnt <= '0;
      frm_drop_cnt <= '0;
    end else begin
      rx_state <= rx_next;
      wr_ptr <= wr_nxt;
      cmt_ptr <= cmt_nxt;
      ovf <= ovf | ovf_set;
      frm_fwd_cnt <= sat(frm_fwd_cnt, {1'b0, fwd_inc});
      frm_drop_cnt <= sat(frm_drop_cnt, drop_inc);
    end

  always_ff @(posedge clk) begin
    if (we) mem[base] <= {mac_rx_eof, mac_rx_data};
    if (issue) ram_q <= mem[rd_ptr];
  end

  // Words of a committed frame are all present, so reading runs unchecked until the eof word surfaces.
  assign avail   = rd_ptr != cmt_ptr;
  assign sending = tx_state == T_READ || tx_state == T_SEND;
  assign q_eof   = ram_q[W];

  always_comb begin
    tx_next = tx_state;
    issue = 1'b0;
    pause_nxt = pause_cnt;
    if (sending) begin
      if (!q_eof) begin
        issue = 1'b1;
        tx_next = T_SEND;
      end else if (PAUSE_SIZE == 16'd0 && avail) begin
        issue = 1'b1;
        tx_next = T_READ;
      end else begin
        tx_next = T_PAUSE;
        pause_nxt = PAUSE_LOAD;
      end
    end else if (pause_cnt != 16'd0) pause_nxt = pause_cnt - 16'd1;
    else if (avail) begin
      issue = 1'b1;
      tx_next = T_READ;
    end else tx_next = T_IDLE;
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      tx_state <= T_IDLE;
      rd_ptr <= '0;
      pause_cnt <= '0;
      mac_tx_data <= '0;
      mac_tx_valid <= 1'b0;
      mac_tx_sof <= 1'b0;
      mac_tx_eof <= 1'b0;
    end else begin
      tx_state <= tx_next;
      pause_cnt <= pause_nxt;
      if (issue) rd_ptr <= rd_ptr + 1'b1;
      mac_tx_valid <= sending;
      mac_tx_sof <= tx_state == T_READ;
      mac_tx_eof <= sending & q_eof;
      mac_tx_data <= sending ? ram_q[W-1:0] : '0;
    end
endmodule
